adc_bcd_display_ctrl: RTL



---
 rtl/adc_bcd_pkg.sv | 36 +++
 rtl/adc_bcd_display_ctrl_seg7.sv | 27 ++
 rtl/adc_bcd_display_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/adc_bcd_pkg.sv
// Shared types and constants for the ADC BCD display controller.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package adc_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        SEL_UNITS,
        SEL_TENS,
        SEL_HUNDREDS
    } dsel_e;

    localparam int BCD_W   = 4;
    localparam int SHIFT_W = 20;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/adc_bcd_display_ctrl_seg7.sv
// Combinational BCD to active-low 7-segment decoder.
// Non-decimal codes render as a blank digit.
module bcd_seg7_decode
    import adc_bcd_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [6:0]       seg_n_o
);

    always_comb begin
        seg_n_o = SEG_BLANK;
        unique case (bcd_i)
            4'd0:    seg_n_o = SEG_0;
            4'd1:    seg_n_o = SEG_1;
            4'd2:    seg_n_o = SEG_2;
            4'd3:    seg_n_o = SEG_3;
            4'd4:    seg_n_o = SEG_4;
            4'd5:    seg_n_o = SEG_5;
            4'd6:    seg_n_o = SEG_6;
            4'd7:    seg_n_o = SEG_7;
            4'd8:    seg_n_o = SEG_8;
            4'd9:    seg_n_o = SEG_9;
            default: seg_n_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/adc_bcd_display_ctrl.sv
// Double-dabble BCD conversion of ADC samples with a muxed 3-digit display.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module adc_bcd_display_ctrl
    import adc_bcd_pkg::*;
#(
    parameter logic [15:0] REFRESH_DIV = 16'd50000,
    parameter int          DATA_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              conv_done,
    output logic [3:0]        hundreds_data,
    output logic [3:0]        tens_data,
    output logic [3:0]        units_data,
    output logic [6:0]        seg_n,
    output logic [2:0]        an_n
);

    state_e               state_q, state_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [SHIFT_W-1:0]   adj;
    logic [2:0]           iter_q, iter_d;
    logic [BCD_W-1:0]     hund_q, hund_d;
    logic [BCD_W-1:0]     tens_q, tens_d;
    logic [BCD_W-1:0]     units_q, units_d;
    logic                 conv_done_q, conv_done_d;
    logic [15:0]          cnt_q, cnt_d;
    dsel_e                sel_q, sel_d;
    logic [2:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic [BCD_W-1:0]     digit_sel;
    logic [6:0]           seg_dec;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        iter_d      = iter_q;
        hund_d      = hund_q;
        tens_d      = tens_q;
        units_d     = units_q;
        conv_done_d = 1'b0;
        adj         = {add3(shift_q[19:16]), add3(shift_q[15:12]),
                       add3(shift_q[11:8]), shift_q[7:0]};
        unique case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    shift_d = {{(SHIFT_W-DATA_W){1'b0}}, sample_data};
                    iter_d  = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = {adj[SHIFT_W-2:0], 1'b0};
                iter_d  = iter_q + 3'd1;
                if (iter_q == 3'd7) state_d = DONE;
            end
            DONE: begin
                hund_d      = shift_q[19:16];
                tens_d      = shift_q[15:12];
                units_d     = shift_q[11:8];
                conv_done_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Display drive uses next-state digits so a DONE update shows immediately.
    always_comb begin
        cnt_d = cnt_q + 16'd1;
        sel_d = sel_q;
        if (cnt_q == REFRESH_DIV - 16'd1) begin
            cnt_d = 16'd0;
            unique case (sel_q)
                SEL_UNITS:    sel_d = SEL_TENS;
                SEL_TENS:     sel_d = SEL_HUNDREDS;
                default:      sel_d = SEL_UNITS;
            endcase
        end
        digit_sel = units_d;
        an_d      = 3'b110;
        unique case (sel_d)
            SEL_TENS: begin
                digit_sel = tens_d;
                an_d      = 3'b101;
`ifdef LEADING_ZERO_BLANK_EN
                if (hund_d == 4'd0 && tens_d == 4'd0) an_d = 3'b111;
`endif
            end
            SEL_HUNDREDS: begin
                digit_sel = hund_d;
                an_d      = 3'b011;
`ifdef LEADING_ZERO_BLANK_EN
                if (hund_d == 4'd0) an_d = 3'b111;
`endif
            end
            default: begin
                digit_sel = units_d;
                an_d      = 3'b110;
            end
        endcase
        seg_d = seg_dec;
    end

    bcd_seg7_decode u_dec (
        .bcd_i   (digit_sel),
        .seg_n_o (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            iter_q      <= 3'd0;
            hund_q      <= '0;
            tens_q      <= '0;
            units_q     <= '0;
            conv_done_q <= 1'b0;
            cnt_q       <= 16'd0;
            sel_q       <= SEL_UNITS;
            an_q        <= 3'b110;
            seg_q       <= SEG_0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            iter_q      <= iter_d;
            hund_q      <= hund_d;
            tens_q      <= tens_d;
            units_q     <= units_d;
            conv_done_q <= conv_done_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign sample_ready  = (state_q == IDLE);
    assign conv_done     = conv_done_q;
    assign hundreds_data = hund_q;
    assign tens_data     = tens_q;
    assign units_data    = units_q;
    assign seg_n         = seg_q;
    assign an_n          = an_q;

endmodule
